muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 67 ++++++
 rtl/muldiv_iter.sv | 66 ++++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the opcode enum, FSM state enum, decode bundle and special results.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    typedef struct packed {
        logic legal;
        logic mul;
        logic w;
        logic sa;
        logic sb;
        logic hi;
        logic rem;
    } md_dec_t;

    localparam logic [63:0] QUO_DIV0 = '1;
    localparam logic [63:0] REM_OVF  = '0;

    // W ops decode as illegal on a 32-bit datapath.
    function automatic md_dec_t md_decode(md_op_t op, logic has_w);
        md_dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_MUL:    d.mul = 1'b1;
            OP_MULH:   begin d.mul = 1'b1; d.sa = 1'b1; d.sb = 1'b1; d.hi = 1'b1; end
            OP_MULHSU: begin d.mul = 1'b1; d.sa = 1'b1; d.hi = 1'b1; end
            OP_MULHU:  begin d.mul = 1'b1; d.hi = 1'b1; end
            OP_DIV:    begin d.sa = 1'b1; d.sb = 1'b1; end
            OP_DIVU:   d.legal = 1'b1;
            OP_REM:    begin d.sa = 1'b1; d.sb = 1'b1; d.rem = 1'b1; end
            OP_REMU:   d.rem = 1'b1;
            OP_MULW:   begin d.mul = 1'b1; d.w = 1'b1; end
            OP_DIVW:   begin d.w = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_DIVUW:  d.w = 1'b1;
            OP_REMW:   begin d.w = 1'b1; d.sa = 1'b1; d.sb = 1'b1; d.rem = 1'b1; end
            OP_REMUW:  begin d.w = 1'b1; d.rem = 1'b1; end
            default:   d.legal = 1'b0;
        endcase
        if (d.w && !has_w) begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Bit-serial unsigned shift-add multiplier / restoring divider core.
// Ports: start_i/kill_i control, mul_i/w_i mode, a_i/b_i magnitudes, acc_o/done_o.
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic              mul_i,
    input  logic              w_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              done_o
);

    logic [2*XLEN-1:0] acc_q, acc_d, mul_nxt, div_nxt;
    logic [XLEN-1:0]   b_q;
    logic [6:0]        cnt_q, last;
    logic              run_q, mul_q, w_q;
    logic [XLEN:0]     sum, rem_sh, diff;

    // Multiply: {hi, multiplier} shifts right, adding b when the lsb is set.
    // Divide: {rem, quo} shifts left, subtracting b when it fits.
    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_nxt = {sum, acc_q[XLEN-1:1]};
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, b_q};
        div_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_d   = mul_q ? mul_nxt : div_nxt;
        last    = w_q ? 7'd31 : 7'(XLEN - 1);
        done_o  = run_q && (cnt_q == last);
        acc_o   = acc_q;
    end

    // A 32-step divide needs its dividend in the top half of the quotient field.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            mul_q <= 1'b0;
            w_q   <= 1'b0;
        end else if (kill_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= {{XLEN{1'b0}}, (w_i && !mul_i) ? (a_i << 32) : a_i};
            b_q   <= b_i;
            cnt_q <= '0;
            run_q <= 1'b1;
            mul_q <= mul_i;
            w_q   <= w_i;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 7'd1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: operand prep, sign fix-up, W sign extension.
// Ports: in_* accept handshake, out_* result handshake, flush abort, busy status.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  md_op_t           in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    md_state_t         state_q, state_d;
    md_dec_t           dec;
    logic              accept, it_done;
    logic              neg_a, neg_b, div0, ovf, special, neg_res;
    logic [XLEN-1:0]   a_w, b_w, a_mag, b_mag, min_mag, spec_val;
    logic [TAG_W-1:0]  tag_q;
    logic              mul_q, w_q, hi_q, rem_q, neg_q, spec_q;
    logic [XLEN-1:0]   spec_val_q;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   dval, dres, raw, res;

    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        dec     = md_decode(in_op, XLEN == 64);
        a_w     = dec.w ? (dec.sa ? XLEN'(signed'(in_a[31:0])) : XLEN'(in_a[31:0])) : in_a;
        b_w     = dec.w ? (dec.sb ? XLEN'(signed'(in_b[31:0])) : XLEN'(in_b[31:0])) : in_b;
        neg_a   = dec.sa && a_w[XLEN-1];
        neg_b   = dec.sb && b_w[XLEN-1];
        a_mag   = neg_a ? -a_w : a_w;
        b_mag   = neg_b ? -b_w : b_w;
        min_mag = XLEN'(1) << (dec.w ? 31 : XLEN - 1);
        div0    = dec.legal && !dec.mul && (b_w == '0);
        ovf     = dec.legal && !dec.mul && dec.sa && neg_a
                  && (a_mag == min_mag) && (b_w == '1);
        special = !dec.legal || div0 || ovf;
        spec_val = '0;
        if (div0) begin
            spec_val = dec.rem ? a_w : QUO_DIV0[XLEN-1:0];
        end else if (ovf) begin
            spec_val = dec.rem ? REM_OVF[XLEN-1:0] : a_w;
        end
        neg_res = dec.rem ? neg_a : (neg_a ^ neg_b);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_q      <= '0;
            mul_q      <= 1'b0;
            w_q        <= 1'b0;
            hi_q       <= 1'b0;
            rem_q      <= 1'b0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
        end else if (accept) begin
            tag_q      <= in_tag;
            mul_q      <= dec.mul;
            w_q        <= dec.w;
            hi_q       <= dec.hi;
            rem_q      <= dec.rem;
            neg_q      <= neg_res;
            spec_q     <= special;
            spec_val_q <= spec_val;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (accept && !special),
        .kill_i  (flush),
        .mul_i   (dec.mul),
        .w_i     (dec.w),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .acc_o   (acc),
        .done_o  (it_done)
    );

    // A 32-step multiply leaves the low product word at acc[XLEN-1:XLEN-32].
    always_comb begin
        prod = neg_q ? -acc : acc;
        dval = rem_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        dres = neg_q ? -dval : dval;
        if (spec_q) begin
            raw = spec_val_q;
        end else if (mul_q && w_q) begin
            raw = XLEN'(acc[XLEN-1:XLEN-32]);
        end else if (mul_q) begin
            raw = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end else begin
            raw = dres;
        end
        res = w_q ? XLEN'(signed'(raw[31:0])) : raw;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: if (it_done)   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        out_result = out_valid ? res : '0;
        out_tag    = out_valid ? tag_q : '0;
    end

endmodule
